snake_engine: RTL and testbench
===============================

// Module: snake_engine
// PURPOSE
//  Parametrised snake game core: grid size, max length and wall mode are set by parameters.
//  Body is held in a circular index buffer plus an occupancy bitmap; no per-move shifting.
//  Food arrives over a req/valid handshake from an external generator.
//  A registered cell-query port feeds the VGA renderer; the engine contains no pixel logic.
// PARAMETERS
//  GRID_W    7   grid columns (>=4)
//  GRID_H    6   grid rows (>=2)
//  MAX_LEN   20  max body length; reaching it wins (4..GRID_W*GRID_H)
//  WALL_WRAP 1   1: head wraps at edges; 0: edge hit is a collision
//  Derived: XW=$clog2(GRID_W), YW=$clog2(GRID_H), LW=$clog2(MAX_LEN+1), NC=GRID_W*GRID_H
// PORTS
//  i_Clk         in   1    system clock
//  i_Rst_L       in   1    asynchronous active-low reset
//  i_Tick        in   1    one-cycle game-step strobe
//  i_Start       in   1    level; starts from IDLE, returns OVER->IDLE
//  i_Up/i_Down/i_Left/i_Right  in  1 each  direction buttons, level, synchronous to i_Clk
//  o_Food_Req    out  1    asserted while a new food position is needed
//  i_Food_Valid  in   1    i_Food_X/Y valid; accepted only when o_Food_Req=1
//  i_Food_X      in   XW   candidate food column
//  i_Food_Y      in   YW   candidate food row
//  i_Qry_X       in   XW   renderer query column
//  i_Qry_Y       in   YW   renderer query row
//  o_Qry_Cell    out  2    0 empty, 1 body, 2 head, 3 food; registered, 1-cycle latency
//  o_State       out  2    0 IDLE, 1 RUNNING, 2 OVER
//  o_Head_X      out  XW   current head column
//  o_Head_Y      out  YW   current head row
//  o_Length      out  LW   current body length
//  o_Collision   out  1    set on wall or self hit; held in OVER
//  o_Win         out  1    set when length reaches MAX_LEN; held in OVER
// BEHAVIOUR
//  Reset values: state IDLE; length 0; bitmap clear; o_Food_Req 0; o_Qry_Cell 0; head (0,0);
//   o_Collision 0; o_Win 0. Reset mid-game aborts immediately to these values.
//  IDLE -> RUNNING when i_Start=1, on any cycle (not gated by i_Tick). Preload:
//   head (GRID_W/2, GRID_H/2); 2 body cells directly left of head; length 3; dir RIGHT;
//   o_Food_Req set to 1 on the same edge.
//  Direction latch: updated every cycle. Priority Up>Down>Left>Right.
//   Reversal of the committed dir is ignored. Latch commits on each RUNNING tick.
//  Move, on i_Tick in RUNNING: next head = head + latched dir.
//   Edge: WALL_WRAP=1 wraps (x=GRID_W-1 -> 0, y=0 -> GRID_H-1); WALL_WRAP=0 sets collision.
//   eat = food_present && next==food.
//   Self hit = bitmap[next] && !( !eat && next==tail ); moving into the vacated tail cell is legal.
//   Commit on the same edge: push next at head ptr; if !eat, pop tail and clear its bit.
//   Outputs reflect the move one cycle after the tick.
//   Collision -> OVER, no move applied, o_Collision=1.
//   eat: length+1, food_present=0, o_Food_Req=1. Length reaching MAX_LEN -> OVER, o_Win=1.
//  Food handshake: when o_Food_Req=1 and i_Food_Valid=1 and the cell is not occupied:
//   latch food, food_present=1, o_Food_Req=0 next cycle. Candidate on an occupied cell
//   (including the next head this cycle) is rejected and o_Food_Req stays 1.
//   Ticks continue while waiting; no eating is possible.
//  Simultaneous tick and food valid: the move is evaluated first; the candidate is checked
//   against the post-move bitmap.
//  OVER: all ticks ignored; i_Start=1 -> IDLE, clearing the bitmap, length, flags and the food request.
//  Ring pointers are modulo MAX_LEN (explicit wrap, no power-of-2 assumption).
//  Cell index = y*GRID_W+x, computed at the width of $clog2(NC).
// STRUCTURE
//  snake_pkg: state codes, dir codes, cell-type codes, and a function xy_to_idx.
//  Sub-module snake_ring_buf: MAX_LEN-deep circular index store with push/pop, head/tail
//   ptrs, and count.
//  The engine owns the FSM, the bitmap, the food handshake and the query register.
// TESTING
//  Start, 3 ticks, no food: head (3,3)->(6,3); o_Length=3; bitmap holds 3 bits.
//  WALL_WRAP=1, head (6,3) RIGHT + tick -> head (0,3). WALL_WRAP=0: same move -> OVER,
//   o_Collision=1, head stays (6,3).
//  Food (5,3) accepted; 2 ticks from (3,3) -> length 4, o_Food_Req=1.
//   Next candidate (4,3), which is body -> rejected; candidate (0,0) -> accepted.
//  Length-4 square loop (head chases tail into the vacated cell) -> no collision.
//   Length-5 U-turn into body -> OVER.
//  MAX_LEN=4: one eat -> o_Win=1, state OVER. i_Start -> IDLE with all flags clear.
//  Pull i_Rst_L low mid-move, then query (3,3) -> o_Qry_Cell=0 next cycle; o_State=IDLE.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared codes and helpers for the snake game core.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BODY  = 2'd1,
    CELL_HEAD  = 2'd2,
    CELL_FOOD  = 2'd3
  } cell_t;

  // Linear cell index, row-major; callers truncate to their index width.
  function automatic logic [15:0] xy_to_idx(input logic [15:0] i_x,
                                            input logic [15:0] i_y,
                                            input logic [15:0] i_w);
    return i_y * i_w + i_x;
  endfunction

  // Direction that would fold the snake back onto its own neck.
  function automatic dir_t dir_opposite(input dir_t i_dir);
    dir_t w_opp;
    case (i_dir)
      DIR_UP:    w_opp = DIR_DOWN;
      DIR_DOWN:  w_opp = DIR_UP;
      DIR_LEFT:  w_opp = DIR_RIGHT;
      DIR_RIGHT: w_opp = DIR_LEFT;
      default:   w_opp = DIR_LEFT;
    endcase
    return w_opp;
  endfunction

endpackage

// File: rtl/snake_ring_buf.sv
// Circular store of body cell indices; tail entry is read combinationally.
module snake_ring_buf #(
  parameter int DEPTH = 20,
  parameter int DW    = 6,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            i_Clk,
  input  logic            i_Rst_L,
  input  logic            i_Clr,
  input  logic            i_Init,
  input  logic [DW-1:0]   i_Init_Tail,
  input  logic [DW-1:0]   i_Init_Mid,
  input  logic [DW-1:0]   i_Init_Head,
  input  logic            i_Push,
  input  logic [DW-1:0]   i_Push_Data,
  input  logic            i_Pop,
  output logic [DW-1:0]   o_Tail_Data,
  output logic [CNTW-1:0] o_Count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0]   PTR_INIT = PW'(3);
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(3);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_head_ptr;
  logic [PW-1:0]   r_tail_ptr;
  logic [CNTW-1:0] r_count;

  // Modulo-DEPTH increment; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i_p);
    return (i_p == PTR_LAST) ? PTR_ZERO : i_p + PTR_ONE;
  endfunction

  // Entry storage: three-cell preload at game start, otherwise one push per move.
  always_ff @(posedge i_Clk) begin
    if (i_Init) begin
      r_mem[0] <= i_Init_Tail;
      r_mem[1] <= i_Init_Mid;
      r_mem[2] <= i_Init_Head;
    end else if (i_Push) begin
      r_mem[r_head_ptr] <= i_Push_Data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_head_ptr <= PTR_ZERO;
      r_tail_ptr <= PTR_ZERO;
      r_count    <= CNT_ZERO;
    end else if (i_Clr) begin
      r_head_ptr <= PTR_ZERO;
      r_tail_ptr <= PTR_ZERO;
      r_count    <= CNT_ZERO;
    end else if (i_Init) begin
      r_head_ptr <= PTR_INIT;
      r_tail_ptr <= PTR_ZERO;
      r_count    <= CNT_INIT;
    end else begin
      if (i_Push) r_head_ptr <= ptr_inc(r_head_ptr);
      if (i_Pop)  r_tail_ptr <= ptr_inc(r_tail_ptr);
      case ({i_Push, i_Pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_Tail_Data = r_mem[r_tail_ptr];
  assign o_Count     = r_count;

endmodule

// File: rtl/snake_engine.sv
// Snake game core: FSM, occupancy bitmap, food handshake and renderer query port.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W    = 7,
  parameter int GRID_H    = 6,
  parameter int MAX_LEN   = 20,
  parameter int WALL_WRAP = 1,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int NC = GRID_W * GRID_H,
  localparam int CW = $clog2(NC)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Tick,
  input  logic          i_Start,
  input  logic          i_Up,
  input  logic          i_Down,
  input  logic          i_Left,
  input  logic          i_Right,
  output logic          o_Food_Req,
  input  logic          i_Food_Valid,
  input  logic [XW-1:0] i_Food_X,
  input  logic [YW-1:0] i_Food_Y,
  input  logic [XW-1:0] i_Qry_X,
  input  logic [YW-1:0] i_Qry_Y,
  output logic [1:0]    o_Qry_Cell,
  output logic [1:0]    o_State,
  output logic [XW-1:0] o_Head_X,
  output logic [YW-1:0] o_Head_Y,
  output logic [LW-1:0] o_Length,
  output logic          o_Collision,
  output logic          o_Win
);
  localparam logic [XW-1:0] X_ZERO  = {XW{1'b0}};
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [XW-1:0] X_LAST  = XW'(GRID_W - 1);
  localparam logic [XW-1:0] X_START = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_ZERO  = {YW{1'b0}};
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [YW-1:0] Y_LAST  = YW'(GRID_H - 1);
  localparam logic [YW-1:0] Y_START = YW'(GRID_H / 2);
  localparam logic [LW-1:0] LEN_PRE_WIN = LW'(MAX_LEN - 1);
  localparam logic [NC-1:0] ONE_BIT  = NC'(1);
  localparam logic [NC-1:0] MAP_ZERO = {NC{1'b0}};
  // Starting body: head at grid centre, two cells trailing to its left.
  localparam logic [CW-1:0] START_IDX = CW'((GRID_H / 2) * GRID_W + GRID_W / 2);
  localparam logic [CW-1:0] START_MID = START_IDX - CW'(1);
  localparam logic [CW-1:0] START_TL  = START_IDX - CW'(2);
  localparam logic [NC-1:0] START_MAP = (ONE_BIT << START_IDX) | (ONE_BIT << START_MID) |
                                        (ONE_BIT << START_TL);

  state_t        r_state, w_state_nxt;
  dir_t          r_dir, r_dir_pend, w_btn_dir;
  logic [XW-1:0] r_head_x, r_food_x, w_next_x;
  logic [YW-1:0] r_head_y, r_food_y, w_next_y;
  logic [NC-1:0] r_bitmap, w_bitmap_mv;
  logic          r_food_present, r_food_req, r_collision, r_win;
  cell_t         r_qry_cell;
  logic [CW-1:0] w_next_idx, w_tail_idx, w_food_idx, w_qry_idx;
  logic [LW-1:0] w_len;
  logic          w_btn_valid, w_edge_hit, w_tick_run, w_eat, w_self_hit;
  logic          w_hit, w_move, w_win, w_pop, w_do_start, w_do_clear;
  logic          w_food_ok, w_food_take, w_qry_in;

  assign w_do_start = (r_state == ST_IDLE) && i_Start;
  assign w_do_clear = (r_state == ST_OVER) && i_Start;
  assign w_tick_run = (r_state == ST_RUN) && i_Tick;

  // Button decode with fixed priority Up > Down > Left > Right.
  always_comb begin
    w_btn_valid = 1'b1;
    w_btn_dir   = DIR_RIGHT;
    if (i_Up)         w_btn_dir = DIR_UP;
    else if (i_Down)  w_btn_dir = DIR_DOWN;
    else if (i_Left)  w_btn_dir = DIR_LEFT;
    else if (i_Right) w_btn_dir = DIR_RIGHT;
    else              w_btn_valid = 1'b0;
  end

  // Candidate head position and edge handling for the pending direction.
  always_comb begin
    w_next_x   = r_head_x;
    w_next_y   = r_head_y;
    w_edge_hit = 1'b0;
    case (r_dir_pend)
      DIR_UP: begin
        if (r_head_y != Y_ZERO)   w_next_y = r_head_y - Y_ONE;
        else if (WALL_WRAP != 0)  w_next_y = Y_LAST;
        else                      w_edge_hit = 1'b1;
      end
      DIR_DOWN: begin
        if (r_head_y != Y_LAST)   w_next_y = r_head_y + Y_ONE;
        else if (WALL_WRAP != 0)  w_next_y = Y_ZERO;
        else                      w_edge_hit = 1'b1;
      end
      DIR_LEFT: begin
        if (r_head_x != X_ZERO)   w_next_x = r_head_x - X_ONE;
        else if (WALL_WRAP != 0)  w_next_x = X_LAST;
        else                      w_edge_hit = 1'b1;
      end
      DIR_RIGHT: begin
        if (r_head_x != X_LAST)   w_next_x = r_head_x + X_ONE;
        else if (WALL_WRAP != 0)  w_next_x = X_ZERO;
        else                      w_edge_hit = 1'b1;
      end
      default: w_edge_hit = 1'b0;
    endcase
  end

  assign w_next_idx = CW'(xy_to_idx(16'(w_next_x), 16'(w_next_y), 16'(GRID_W)));
  assign w_eat      = r_food_present && (w_next_x == r_food_x) && (w_next_y == r_food_y);
  // The tail cell is vacated by this same move unless the snake grows.
  assign w_self_hit = r_bitmap[w_next_idx] && !(!w_eat && (w_next_idx == w_tail_idx));
  assign w_hit      = w_tick_run && (w_edge_hit || w_self_hit);
  assign w_move     = w_tick_run && !w_edge_hit && !w_self_hit;
  assign w_pop      = w_move && !w_eat;
  assign w_win      = w_move && w_eat && (w_len == LEN_PRE_WIN);

  // Bitmap after this cycle's move: tail cleared before head set so a chase into the tail keeps its bit.
  assign w_bitmap_mv = (r_bitmap & ~(w_pop ? (ONE_BIT << w_tail_idx) : MAP_ZERO)) |
                       (w_move ? (ONE_BIT << w_next_idx) : MAP_ZERO);

  // Food candidates are validated against the post-move body.
  assign w_food_idx  = CW'(xy_to_idx(16'(i_Food_X), 16'(i_Food_Y), 16'(GRID_W)));
  assign w_food_ok   = (i_Food_X <= X_LAST) && (i_Food_Y <= Y_LAST) && !w_bitmap_mv[w_food_idx];
  assign w_food_take = (r_state == ST_RUN) && !w_hit && r_food_req && i_Food_Valid && w_food_ok;

  assign w_qry_idx = CW'(xy_to_idx(16'(i_Qry_X), 16'(i_Qry_Y), 16'(GRID_W)));
  assign w_qry_in  = (i_Qry_X <= X_LAST) && (i_Qry_Y <= Y_LAST);

  snake_ring_buf #(.DEPTH(MAX_LEN), .DW(CW), .CNTW(LW)) u_ring (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Clr       (w_do_clear),
    .i_Init      (w_do_start),
    .i_Init_Tail (START_TL),
    .i_Init_Mid  (START_MID),
    .i_Init_Head (START_IDX),
    .i_Push      (w_move),
    .i_Push_Data (w_next_idx),
    .i_Pop       (w_pop),
    .o_Tail_Data (w_tail_idx),
    .o_Count     (w_len)
  );

  // Game state register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Game state transitions.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = i_Start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_state_nxt = (w_hit || w_win) ? ST_OVER : ST_RUN;
      ST_OVER: w_state_nxt = i_Start ? ST_IDLE : ST_OVER;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Direction latch, head, bitmap, food handshake and end-of-game flags.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_dir          <= DIR_RIGHT;
      r_dir_pend     <= DIR_RIGHT;
      r_head_x       <= X_ZERO;
      r_head_y       <= Y_ZERO;
      r_bitmap       <= MAP_ZERO;
      r_food_x       <= X_ZERO;
      r_food_y       <= Y_ZERO;
      r_food_present <= 1'b0;
      r_food_req     <= 1'b0;
      r_collision    <= 1'b0;
      r_win          <= 1'b0;
    end else begin
      if (w_do_start) begin
        r_dir      <= DIR_RIGHT;
        r_dir_pend <= DIR_RIGHT;
      end else begin
        if (w_btn_valid && (w_btn_dir != dir_opposite(r_dir))) r_dir_pend <= w_btn_dir;
        if (w_tick_run) r_dir <= r_dir_pend;
      end

      if (w_do_start) begin
        r_head_x <= X_START;
        r_head_y <= Y_START;
      end else if (w_move) begin
        r_head_x <= w_next_x;
        r_head_y <= w_next_y;
      end

      if (w_do_start)      r_bitmap <= START_MAP;
      else if (w_do_clear) r_bitmap <= MAP_ZERO;
      else                 r_bitmap <= w_bitmap_mv;

      if (w_do_start || w_do_clear) begin
        r_food_present <= 1'b0;
        r_food_req     <= w_do_start;
      end else if (w_move && w_eat) begin
        r_food_present <= 1'b0;
        r_food_req     <= !w_win;
      end else if (w_food_take) begin
        r_food_present <= 1'b1;
        r_food_req     <= 1'b0;
        r_food_x       <= i_Food_X;
        r_food_y       <= i_Food_Y;
      end

      if (w_do_clear) begin
        r_collision <= 1'b0;
        r_win       <= 1'b0;
      end else begin
        if (w_hit) r_collision <= 1'b1;
        if (w_win) r_win       <= 1'b1;
      end
    end
  end

  // Registered cell lookup for the renderer.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_qry_cell <= CELL_EMPTY;
    end else if (!w_qry_in) begin
      r_qry_cell <= CELL_EMPTY;
    end else if (r_bitmap[w_qry_idx]) begin
      r_qry_cell <= ((i_Qry_X == r_head_x) && (i_Qry_Y == r_head_y)) ? CELL_HEAD : CELL_BODY;
    end else if (r_food_present && (i_Qry_X == r_food_x) && (i_Qry_Y == r_food_y)) begin
      r_qry_cell <= CELL_FOOD;
    end else begin
      r_qry_cell <= CELL_EMPTY;
    end
  end

  assign o_Food_Req  = r_food_req;
  assign o_Qry_Cell  = r_qry_cell;
  assign o_State     = r_state;
  assign o_Head_X    = r_head_x;
  assign o_Head_Y    = r_head_y;
  assign o_Length    = w_len;
  assign o_Collision = r_collision;
  assign o_Win       = r_win;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench: wrapping, non-wrapping and MAX_LEN=4 engines share one stimulus stream.
module tb_snake_engine;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0;
  logic up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0, fvalid = 1'b0;
  logic [2:0] fx = 3'd0, fy = 3'd0, qx = 3'd0, qy = 3'd0;
  int errors = 0, checks = 0;

  logic       a_req, a_col, a_win, b_req, b_col, b_win, c_req, c_col, c_win;
  logic [1:0] a_cell, a_state, b_cell, b_state, c_cell, c_state;
  logic [2:0] a_hx, a_hy, b_hx, b_hy, c_hx, c_hy, c_len;
  logic [4:0] a_len, b_len;

  always #5 clk = ~clk;

  snake_engine #(.GRID_W(7), .GRID_H(6), .MAX_LEN(20), .WALL_WRAP(1)) u_wrap (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Tick(tick), .i_Start(start), .i_Up(up), .i_Down(dn),
    .i_Left(lf), .i_Right(rt), .o_Food_Req(a_req), .i_Food_Valid(fvalid), .i_Food_X(fx),
    .i_Food_Y(fy), .i_Qry_X(qx), .i_Qry_Y(qy), .o_Qry_Cell(a_cell), .o_State(a_state),
    .o_Head_X(a_hx), .o_Head_Y(a_hy), .o_Length(a_len), .o_Collision(a_col), .o_Win(a_win));

  snake_engine #(.GRID_W(7), .GRID_H(6), .MAX_LEN(20), .WALL_WRAP(0)) u_nowrap (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Tick(tick), .i_Start(start), .i_Up(up), .i_Down(dn),
    .i_Left(lf), .i_Right(rt), .o_Food_Req(b_req), .i_Food_Valid(fvalid), .i_Food_X(fx),
    .i_Food_Y(fy), .i_Qry_X(qx), .i_Qry_Y(qy), .o_Qry_Cell(b_cell), .o_State(b_state),
    .o_Head_X(b_hx), .o_Head_Y(b_hy), .o_Length(b_len), .o_Collision(b_col), .o_Win(b_win));

  snake_engine #(.GRID_W(7), .GRID_H(6), .MAX_LEN(4), .WALL_WRAP(1)) u_small (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Tick(tick), .i_Start(start), .i_Up(up), .i_Down(dn),
    .i_Left(lf), .i_Right(rt), .o_Food_Req(c_req), .i_Food_Valid(fvalid), .i_Food_X(fx),
    .i_Food_Y(fy), .i_Qry_X(qx), .i_Qry_Y(qy), .o_Qry_Cell(c_cell), .o_State(c_state),
    .o_Head_X(c_hx), .o_Head_Y(c_hy), .o_Length(c_len), .o_Collision(c_col), .o_Win(c_win));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; fvalid = 1'b0;
    up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
  endtask

  // 0 up, 1 down, 2 left, 3 right
  task automatic press(input int d);
    up = (d == 0); dn = (d == 1); lf = (d == 2); rt = (d == 3);
    cyc();
    up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0;
  endtask

  task automatic offer(input logic [2:0] x, input logic [2:0] y);
    fx = x; fy = y; fvalid = 1'b1; cyc(); fvalid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    qx = 3'd3; qy = 3'd3; cyc();
    checks++;
    if ({a_state, a_len, a_hx, a_hy} !== 16'h0) begin
      errors++; $display("FAIL reset_regs: got st=%0d len=%0d head=(%0d,%0d) expected all 0", a_state, a_len, a_hx, a_hy);
    end
    checks++;
    if ({a_col, a_win, a_req, a_cell} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got col=%0d win=%0d req=%0d cell=%0d expected all 0", a_col, a_win, a_req, a_cell);
    end
  endtask

  task automatic test_start_move();
    int cnt;
    do_start();
    checks++;
    if ({a_state, a_hx, a_hy, a_len, a_req} !== {2'd1, 3'd3, 3'd3, 5'd3, 1'b1}) begin
      errors++; $display("FAIL start_preload: got st=%0d head=(%0d,%0d) len=%0d req=%0d expected 1 (3,3) 3 1", a_state, a_hx, a_hy, a_len, a_req);
    end
    do_tick(); do_tick(); do_tick();
    checks++;
    if ({a_hx, a_hy, a_len} !== {3'd6, 3'd3, 5'd3}) begin
      errors++; $display("FAIL move3: got head=(%0d,%0d) len=%0d expected (6,3) 3", a_hx, a_hy, a_len);
    end
    qx = 3'd6; qy = 3'd3; cyc();
    checks++;
    if (a_cell !== 2'd2) begin errors++; $display("FAIL qry_head: got %0d expected 2", a_cell); end
    qx = 3'd4; cyc();
    checks++;
    if (a_cell !== 2'd1) begin errors++; $display("FAIL qry_body: got %0d expected 1", a_cell); end
    qx = 3'd3; cyc();
    checks++;
    if (a_cell !== 2'd0) begin errors++; $display("FAIL qry_vacated: got %0d expected 0", a_cell); end
    cnt = 0;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 7; x++) begin
        qx = 3'(x); qy = 3'(y); cyc();
        if (a_cell == 2'd1 || a_cell == 2'd2) cnt++;
      end
    end
    checks++;
    if (cnt !== 3) begin errors++; $display("FAIL bitmap_count: got %0d expected 3", cnt); end
  endtask

  task automatic test_wrap();
    do_tick();
    checks++;
    if ({a_hx, a_hy, a_state} !== {3'd0, 3'd3, 2'd1}) begin
      errors++; $display("FAIL wrap_head: got (%0d,%0d) st=%0d expected (0,3) 1", a_hx, a_hy, a_state);
    end
    checks++;
    if ({b_state, b_col, b_hx, b_hy} !== {2'd2, 1'b1, 3'd6, 3'd3}) begin
      errors++; $display("FAIL wall_hit: got st=%0d col=%0d head=(%0d,%0d) expected 2 1 (6,3)", b_state, b_col, b_hx, b_hy);
    end
    do_tick();
    checks++;
    if ({b_state, b_col, b_hx} !== {2'd2, 1'b1, 3'd6}) begin
      errors++; $display("FAIL over_hold: got st=%0d col=%0d x=%0d expected 2 1 6", b_state, b_col, b_hx);
    end
  endtask

  task automatic test_food_and_win();
    do_reset(); do_start();
    offer(3'd5, 3'd3);
    checks++;
    if (a_req !== 1'b0) begin errors++; $display("FAIL food_accept: got req=%0d expected 0", a_req); end
    qx = 3'd5; qy = 3'd3; cyc();
    checks++;
    if (a_cell !== 2'd3) begin errors++; $display("FAIL qry_food: got %0d expected 3", a_cell); end
    do_tick(); do_tick();
    checks++;
    if ({a_hx, a_hy, a_len, a_req} !== {3'd5, 3'd3, 5'd4, 1'b1}) begin
      errors++; $display("FAIL eat: got head=(%0d,%0d) len=%0d req=%0d expected (5,3) 4 1", a_hx, a_hy, a_len, a_req);
    end
    checks++;
    if ({c_state, c_win, c_col, c_len} !== {2'd2, 1'b1, 1'b0, 3'd4}) begin
      errors++; $display("FAIL win: got st=%0d win=%0d col=%0d len=%0d expected 2 1 0 4", c_state, c_win, c_col, c_len);
    end
    offer(3'd4, 3'd3);
    checks++;
    if (a_req !== 1'b1) begin errors++; $display("FAIL food_on_body: got req=%0d expected 1", a_req); end
    offer(3'd0, 3'd0);
    qx = 3'd0; qy = 3'd0; cyc();
    checks++;
    if ({a_req, a_cell} !== {1'b0, 2'd3}) begin
      errors++; $display("FAIL food_second: got req=%0d cell=%0d expected 0 3", a_req, a_cell);
    end
    do_start();
    checks++;
    if ({c_state, c_win, c_col, c_req, c_len} !== 8'h0) begin
      errors++; $display("FAIL over_to_idle: got st=%0d win=%0d col=%0d req=%0d len=%0d expected all 0", c_state, c_win, c_col, c_req, c_len);
    end
    checks++;
    if (a_state !== 2'd1) begin errors++; $display("FAIL run_ignores_start: got %0d expected 1", a_state); end
  endtask

  task automatic test_loop();
    press(1); do_tick();
    press(2); do_tick();
    press(0); do_tick();
    checks++;
    if ({a_hx, a_hy, a_col, a_state} !== {3'd4, 3'd3, 1'b0, 2'd1}) begin
      errors++; $display("FAIL chase_tail: got head=(%0d,%0d) col=%0d st=%0d expected (4,3) 0 1", a_hx, a_hy, a_col, a_state);
    end
    press(3); do_tick();
    checks++;
    if ({a_hx, a_hy, a_len, a_col} !== {3'd5, 3'd3, 5'd4, 1'b0}) begin
      errors++; $display("FAIL square_loop: got head=(%0d,%0d) len=%0d col=%0d expected (5,3) 4 0", a_hx, a_hy, a_len, a_col);
    end
  endtask

  task automatic test_uturn();
    do_reset(); do_start();
    offer(3'd4, 3'd3);
    press(2); do_tick();
    checks++;
    if ({a_hx, a_hy, a_len} !== {3'd4, 3'd3, 5'd4}) begin
      errors++; $display("FAIL reversal_ignored: got head=(%0d,%0d) len=%0d expected (4,3) 4", a_hx, a_hy, a_len);
    end
    offer(3'd5, 3'd3); do_tick();
    press(1); do_tick();
    press(2); do_tick();
    press(0); do_tick();
    checks++;
    if ({a_state, a_col, a_hx, a_hy, a_len} !== {2'd2, 1'b1, 3'd4, 3'd4, 5'd5}) begin
      errors++; $display("FAIL self_hit: got st=%0d col=%0d head=(%0d,%0d) len=%0d expected 2 1 (4,4) 5", a_state, a_col, a_hx, a_hy, a_len);
    end
  endtask

  task automatic test_tick_food();
    do_reset(); do_start();
    fx = 3'd4; fy = 3'd3; fvalid = 1'b1; tick = 1'b1;
    cyc();
    fvalid = 1'b0; tick = 1'b0;
    checks++;
    if ({a_hx, a_req} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL food_on_next_head: got x=%0d req=%0d expected 4 1", a_hx, a_req);
    end
    offer(3'd1, 3'd3);
    qx = 3'd1; qy = 3'd3; cyc();
    checks++;
    if ({a_req, a_cell} !== {1'b0, 2'd3}) begin
      errors++; $display("FAIL food_on_vacated: got req=%0d cell=%0d expected 0 3", a_req, a_cell);
    end
  endtask

  task automatic test_reset_mid();
    tick = 1'b1;
    #2 rst_n = 1'b0;
    cyc();
    tick = 1'b0;
    checks++;
    if ({a_state, a_len, a_hx, a_hy, a_req} !== 17'h0) begin
      errors++; $display("FAIL mid_reset: got st=%0d len=%0d head=(%0d,%0d) req=%0d expected all 0", a_state, a_len, a_hx, a_hy, a_req);
    end
    rst_n = 1'b1;
    qx = 3'd3; qy = 3'd3; cyc();
    checks++;
    if ({a_cell, a_state} !== 4'h0) begin
      errors++; $display("FAIL post_reset_qry: got cell=%0d st=%0d expected 0 0", a_cell, a_state);
    end
  endtask

  initial begin
    test_reset();
    test_start_move();
    test_wrap();
    test_food_and_win();
    test_loop();
    test_uturn();
    test_tick_food();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
